// File: rtl/stream_arbiter.sv
// N-to-1 round-robin stream merger with a small registered output FIFO.
// Optional build macro STREAM_ARBITER_TAG_EN stamps the granted source index into the message MSBs.
module stream_arbiter #(
  parameter int nbits   = 32,
  parameter int ninputs = 8,
  parameter int nbufs   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             istream_val [0:ninputs-1],
  input  logic [nbits-1:0] istream_msg [0:ninputs-1],
  output logic             istream_rdy [0:ninputs-1],
  output logic             ostream_val,
  output logic [nbits-1:0] ostream_msg,
  input  logic             ostream_rdy
);

  localparam int PW = $clog2(ninputs);
  localparam int AW = $clog2(nbufs);
  localparam int CW = $clog2(nbufs + 1);

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [nbits-1:0] mem_q [nbufs];

  logic             space;
  logic             any_val;
  logic             accept;
  logic             deq;
  logic [PW-1:0]    grant;
  logic [nbits-1:0] enq_msg;

  // Adds an offset below ninputs and wraps, so non-power-of-2 sizes never overflow the range.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= ninputs) s = s - ninputs;
    return PW'(s);
  endfunction

  function automatic logic [AW-1:0] buf_inc(input logic [AW-1:0] p);
    return (p == AW'(nbufs - 1)) ? '0 : p + 1'b1;
  endfunction

  // Space excludes the full-with-dequeue case so istream_rdy never depends on ostream_rdy.
  assign space = cnt_q < CW'(nbufs);

  // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    grant   = '0;
    any_val = 1'b0;
    for (int k = 0; k < ninputs; k++) begin
      if (!any_val && istream_val[wrap_add(ptr_q, k)]) begin
        any_val = 1'b1;
        grant   = wrap_add(ptr_q, k);
      end
    end
  end

  assign accept = space && any_val;

  // Gated by reset so the ready outputs drop the moment reset asserts.
  always_comb begin
    for (int i = 0; i < ninputs; i++) begin
      istream_rdy[i] = !reset && accept && (grant == PW'(i));
    end
  end

  always_comb begin
    enq_msg = istream_msg[grant];
`ifdef STREAM_ARBITER_TAG_EN
    enq_msg[nbits-1 -: PW] = grant;
`endif
  end

  assign ostream_val = cnt_q != '0;
  assign ostream_msg = mem_q[rd_q];
  assign deq         = ostream_val && ostream_rdy;

  always_comb begin
    ptr_d = ptr_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (accept) begin
      ptr_d = wrap_add(grant, 1);
      wr_d  = buf_inc(wr_q);
    end
    if (deq) rd_d = buf_inc(rd_q);
    case ({accept, deq})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: payload storage is not reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_q] <= enq_msg;
  end

endmodule

// File: tb/tb_stream_arbiter.sv
// Scoreboard bench for stream_arbiter (ninputs=4, nbufs=2, nbits=32); honours STREAM_ARBITER_TAG_EN.
module tb_stream_arbiter;

  localparam int NI = 4;
  localparam int NB = 2;
  localparam int W  = 32;

  logic         clk;
  logic         reset;
  logic         val [0:NI-1];
  logic [W-1:0] msg [0:NI-1];
  logic         rdy [0:NI-1];
  logic         ostream_val;
  logic [W-1:0] ostream_msg;
  logic         ostream_rdy;

  stream_arbiter #(.nbits(W), .ninputs(NI), .nbufs(NB)) dut (
    .clk         (clk),
    .reset       (reset),
    .istream_val (val),
    .istream_msg (msg),
    .istream_rdy (rdy),
    .ostream_val (ostream_val),
    .ostream_msg (ostream_msg),
    .ostream_rdy (ostream_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] log_msg [$];
  int           log_cyc [$];
  int           acc_cyc [$];
  int           m_ptr = 0;
  int           cyc = 0;
  logic [NI-1:0] last_rdy;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [NI-1:0] rdy_vec();
    logic [NI-1:0] v;
    for (int i = 0; i < NI; i++) v[i] = rdy[i];
    return v;
  endfunction

  function automatic logic [W-1:0] tagit(input logic [W-1:0] m, input int g);
    logic [W-1:0] r;
    r = m;
`ifdef STREAM_ARBITER_TAG_EN
    r[W-1 -: 2] = 2'(g);
`endif
    return r;
  endfunction

  // One cycle: check outputs against the model mid-cycle, then advance the model at the edge.
  task automatic step();
    bit            found;
    bit            space;
    bit            ofire;
    int            g;
    int            idx;
    logic [NI-1:0] exp_rdy;
    @(negedge clk);
    found = 1'b0;
    g = 0;
    for (int k = 0; k < NI; k++) begin
      idx = (m_ptr + k) % NI;
      if (!found && val[idx]) begin
        found = 1'b1;
        g = idx;
      end
    end
    space = exp_q.size() < NB;
    exp_rdy = '0;
    if (found && space) exp_rdy[g] = 1'b1;
    last_rdy = rdy_vec();
    check("rdy", W'(last_rdy), W'(exp_rdy));
    check("oval", W'(ostream_val), W'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("omsg", ostream_msg, exp_q[0]);
    ofire = (exp_q.size() != 0) && ostream_rdy;
    if (ostream_val && ostream_rdy) begin
      log_msg.push_back(ostream_msg);
      log_cyc.push_back(cyc);
    end
    @(posedge clk);
    if (ofire) void'(exp_q.pop_front());
    if (found && space) begin
      exp_q.push_back(tagit(msg[g], g));
      m_ptr = (g + 1) % NI;
      acc_cyc.push_back(cyc);
    end
    cyc++;
    #1;
  endtask

  task automatic chk_log(input string tag, input int j, input logic [W-1:0] exp);
    if (j < log_msg.size()) check(tag, log_msg[j], exp);
    else check({tag, "_cnt"}, W'(log_msg.size()), W'(j + 1));
  endtask

  task automatic chk_cyc(input string tag, input int j, input int exp);
    if (j < log_cyc.size()) check(tag, W'(log_cyc[j]), W'(exp));
    else check({tag, "_cnt"}, W'(log_cyc.size()), W'(j + 1));
  endtask

  task automatic clear_logs();
    log_msg.delete();
    log_cyc.delete();
    acc_cyc.delete();
  endtask

  logic [NI-1:0] exp_skip [4];
  logic [NI-1:0] bp_rdy [5];
  int            n_acc;

  initial begin
    reset       = 1'b1;
    ostream_rdy = 1'b1;
    for (int i = 0; i < NI; i++) begin
      val[i] = 1'b0;
      msg[i] = 32'h0000_00A0 + W'(i);
    end
    #2;
    check("rst_oval", W'(ostream_val), '0);
    check("rst_rdy", W'(rdy_vec()), '0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Round-robin over four always-valid sources.
    for (int i = 0; i < NI; i++) val[i] = 1'b1;
    clear_logs();
    step();
    check("rr_first_grant", W'(last_rdy), W'(4'b0001));
    repeat (9) step();
    for (int j = 0; j < 8; j++) chk_log("rr_seq", j, 32'h0000_00A0 + W'(j % NI));
    if (acc_cyc.size() > 0) chk_cyc("rr_latency", 0, acc_cyc[0] + 1);
    for (int j = 1; j < 8; j++) if (j < log_cyc.size()) chk_cyc("rr_rate", j, log_cyc[j-1] + 1);

    // Ten grants leave ptr at 2: sources 1 and 3 alternate, starting with 3.
    val[0] = 1'b0;
    val[2] = 1'b0;
    exp_skip = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
    for (int j = 0; j < 4; j++) begin
      step();
      check("skip_wrap", W'(last_rdy), W'(exp_skip[j]));
    end

    // Asynchronous reset mid-cycle while everything is valid and the FIFO is occupied.
    for (int i = 0; i < NI; i++) val[i] = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("arst_oval", W'(ostream_val), '0);
    check("arst_rdy", W'(rdy_vec()), '0);
    exp_q.delete();
    m_ptr = 0;
    ostream_rdy = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Backpressure: two accepts (0 then 1), then blocked until the consumer drains.
    n_acc = 0;
    for (int j = 0; j < 5; j++) begin
      step();
      bp_rdy[j] = last_rdy;
      if (last_rdy != '0) n_acc++;
    end
    check("bp_accepts", W'(n_acc), 32'd2);
    check("bp_grant0", W'(bp_rdy[0]), W'(4'b0001));
    check("bp_grant1", W'(bp_rdy[1]), W'(4'b0010));
    check("bp_blocked", W'(bp_rdy[4]), '0);
    clear_logs();
    ostream_rdy = 1'b1;
    repeat (3) step();
    chk_log("bp_out0", 0, 32'h0000_00A0);
    chk_log("bp_out1", 1, 32'h0000_00A1);
    chk_log("bp_out2", 2, 32'h0000_00A2);

    // Single source, back-to-back messages.
    for (int i = 0; i < NI; i++) val[i] = 1'b0;
    repeat (4) step();
    clear_logs();
    val[2] = 1'b1;
    msg[2] = 32'h11;
    step();
    msg[2] = 32'h22;
    step();
    msg[2] = 32'h33;
    step();
    val[2] = 1'b0;
    repeat (3) step();
    chk_log("single0", 0, 32'h11);
    chk_log("single1", 1, 32'h22);
    chk_log("single2", 2, 32'h33);
    if (acc_cyc.size() > 0) chk_cyc("single_latency", 0, acc_cyc[0] + 1);
    for (int j = 1; j < 3; j++) if (j < log_cyc.size()) chk_cyc("single_rate", j, log_cyc[j-1] + 1);

    // Source-index stamping.
    clear_logs();
    val[3] = 1'b1;
    msg[3] = 32'h0123_4567;
    step();
    val[3] = 1'b0;
    repeat (2) step();
`ifdef STREAM_ARBITER_TAG_EN
    chk_log("tag_msg", 0, 32'hC123_4567);
`else
    chk_log("tag_msg", 0, 32'h0123_4567);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
